// File: rtl/therm_ramp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : therm_ramp_ctrl_if
// Brief    : Target handshake and thermometer-code status bundle.
// Revision : 1.0
// ============================================================================
interface therm_ramp_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int c_LVL_W = $clog2(DATA_WIDTH + 1);

  logic                  tgt_valid;
  logic                  tgt_ready;
  logic [DATA_WIDTH-1:0] tgt_code;
  logic                  abort;
  logic [DATA_WIDTH-1:0] codeOut;
  logic [c_LVL_W-1:0]    level;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output tgt_valid, tgt_code, abort,
    input  tgt_ready, codeOut, level, busy, done, err
  );

  modport slave (
    input  tgt_valid, tgt_code, abort,
    output tgt_ready, codeOut, level, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/therm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : therm_ramp_ctrl
// Brief    : Walks a thermometer code toward a validated target, one unit
//            element per STEP_DIV clocks.
// Revision : 1.0
// ============================================================================
module therm_ramp_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int STEP_DIV   = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  therm_ramp_ctrl_if.slave bus
);
  localparam int c_LVL_W = $clog2(DATA_WIDTH + 1);
  localparam int c_CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [c_CNT_W-1:0]    c_RELOAD   = c_CNT_W'(STEP_DIV - 1);
  localparam logic [c_LVL_W-1:0]    c_LVL_ONE  = c_LVL_W'(1);
  localparam logic [DATA_WIDTH-1:0] c_CODE_ONE = DATA_WIDTH'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_code, w_code_nxt;
  logic [DATA_WIDTH-1:0] r_tgt, w_tgt_nxt;
  logic [c_LVL_W-1:0]    r_level, w_level_nxt;
  logic [c_CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;

  logic                  w_in_legal;
  logic [c_LVL_W-1:0]    w_tgt_level;
  logic                  w_step_up;
  logic [DATA_WIDTH-1:0] w_step_code;
  logic [c_LVL_W-1:0]    w_step_level;

  function automatic logic [c_LVL_W-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
    logic [c_LVL_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      n = n + {{(c_LVL_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  // A thermometer code is 2^k-1, so adding one clears every set bit.
  assign w_in_legal   = ((bus.tgt_code & (bus.tgt_code + c_CODE_ONE)) == '0);
  assign w_tgt_level  = popcount(r_tgt);
  assign w_step_up    = (w_tgt_level > r_level);
  assign w_step_code  = w_step_up ? {r_code[DATA_WIDTH-2:0], 1'b1}
                                  : {1'b0, r_code[DATA_WIDTH-1:1]};
  assign w_step_level = w_step_up ? (r_level + c_LVL_ONE) : (r_level - c_LVL_ONE);

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_level_nxt = r_level;
    w_tgt_nxt   = r_tgt;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.tgt_valid) begin
          if (!w_in_legal) begin
            w_err_nxt = 1'b1;
          end else begin
            w_tgt_nxt = bus.tgt_code;
            if (bus.tgt_code == r_code) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = S_RAMP;
              w_cnt_nxt   = c_RELOAD;
            end
          end
        end
      end
      S_RAMP: begin
        // Abort wins over a step falling due on the same edge.
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_code_nxt  = w_step_code;
          w_level_nxt = w_step_level;
          w_cnt_nxt   = c_RELOAD;
          if (w_step_code == r_tgt) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_level <= '0;
      r_tgt   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_level <= w_level_nxt;
      r_tgt   <= w_tgt_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.tgt_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state == S_RAMP);
  assign bus.codeOut   = r_code;
  assign bus.level     = r_level;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_therm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_therm_ramp_ctrl
// Brief    : Scoreboard bench for therm_ramp_ctrl with a level-based model.
// Revision : 1.0
// ============================================================================
module tb_therm_ramp_ctrl;
  localparam int W  = 8;
  localparam int SD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  therm_ramp_ctrl_if #(.DATA_WIDTH(W)) bus ();

  therm_ramp_ctrl #(.DATA_WIDTH(W), .STEP_DIV(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit is_err; int cyc; int lvl; } evt_t;
  typedef struct { int cyc; int lvl; } chg_t;

  evt_t evq[$];
  chg_t chgq[$];
  int   checks = 0;
  int   errors = 0;
  int   ramp_s = 0;
  int   ramp_e = 0;
  int   m_lvl  = 0;
  logic [W-1:0] mon_prev = '0;

  function automatic logic [W-1:0] therm(input int l);
    logic [W:0] t;
    t = (9'd1 << l) - 9'd1;
    return t[W-1:0];
  endfunction

  // Returns the level of a legal thermometer code, or -1 if illegal.
  function automatic int therm_level(input logic [W-1:0] code);
    for (int l = 0; l <= W; l++) begin
      if (therm(l) == code) return l;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops expected events whenever the DUT shows a pulse or code change.
  initial begin
    evt_t e;
    chg_t c;
    int   exp_busy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev = bus.codeOut;
      end else begin
        exp_busy = (cyc >= ramp_s && cyc < ramp_e) ? 1 : 0;
        chk("busy", int'(bus.busy), exp_busy);
        chk("tgt_ready", int'(bus.tgt_ready), 1 - exp_busy);
        chk("done_err_excl", int'(bus.done & bus.err), 0);
        while (evq.size() > 0 && evq[0].cyc < cyc) begin
          e = evq.pop_front();
          checks++; errors++;
          $display("FAIL missing_event: %s expected at cycle %0d, none by %0d",
                   e.is_err ? "err" : "done", e.cyc, cyc);
        end
        while (chgq.size() > 0 && chgq[0].cyc < cyc) begin
          c = chgq.pop_front();
          checks++; errors++;
          $display("FAIL missing_step: level %0d expected at cycle %0d, none by %0d",
                   c.lvl, c.cyc, cyc);
        end
        if (bus.done || bus.err) begin
          if (evq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pulse at cycle %0d: done=%0b err=%0b, expected none",
                     cyc, bus.done, bus.err);
          end else begin
            e = evq.pop_front();
            chk("pulse_kind_err", int'(bus.err), int'(e.is_err));
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_code", int'(bus.codeOut), int'(therm(e.lvl)));
            chk("pulse_level", int'(bus.level), e.lvl);
          end
        end
        if (bus.codeOut != mon_prev) begin
          if (chgq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_step at cycle %0d: code %0h, expected %0h",
                     cyc, bus.codeOut, mon_prev);
          end else begin
            c = chgq.pop_front();
            chk("step_cycle", cyc, c.cyc);
            chk("step_code", int'(bus.codeOut), int'(therm(c.lvl)));
            chk("step_level", int'(bus.level), c.lvl);
          end
        end
        mon_prev = bus.codeOut;
      end
    end
  end

  task automatic run(input logic [W-1:0] code, input int abort_off,
                     input bit offer_mid, input bit idle_abort);
    int e0, tl, n, steps, endc, aedge;
    bit up;
    @(negedge clk);
    bus.tgt_valid = 1'b1;
    bus.tgt_code  = code;
    bus.abort     = idle_abort;
    @(posedge clk); #1;
    e0 = cyc;
    bus.tgt_valid = 1'b0;
    bus.abort     = 1'b0;
    tl = therm_level(code);
    if (tl < 0) begin
      evq.push_back('{is_err: 1'b1, cyc: e0, lvl: m_lvl});
      return;
    end
    if (tl == m_lvl) begin
      evq.push_back('{is_err: 1'b0, cyc: e0, lvl: m_lvl});
      return;
    end
    up    = (tl > m_lvl);
    n     = up ? tl - m_lvl : m_lvl - tl;
    aedge = (abort_off >= 1 && abort_off <= n * SD) ? e0 + abort_off : 0;
    steps = (aedge != 0) ? (abort_off - 1) / SD : n;
    if (steps > n) steps = n;
    for (int k = 1; k <= steps; k++) begin
      chgq.push_back('{cyc: e0 + k * SD, lvl: up ? m_lvl + k : m_lvl - k});
    end
    endc = (aedge != 0) ? aedge : e0 + n * SD;
    if (aedge == 0) evq.push_back('{is_err: 1'b0, cyc: endc, lvl: tl});
    ramp_s = e0;
    ramp_e = endc;
    for (int c = e0; c < endc; c++) begin
      @(negedge clk);
      bus.abort     = (aedge != 0) && (c + 1 == aedge);
      bus.tgt_valid = offer_mid && (c == e0 + 1);
      bus.tgt_code  = 8'h01;
    end
    m_lvl = up ? m_lvl + steps : m_lvl - steps;
  endtask

  initial begin
    int e0, sel, lvl;
    logic [W-1:0] code;
    bus.tgt_valid = 1'b0;
    bus.tgt_code  = '0;
    bus.abort     = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_code", int'(bus.codeOut), 0);
    chk("rst_level", int'(bus.level), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ready", int'(bus.tgt_ready), 1);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);

    run(8'h0F, 0, 1'b0, 1'b0);
    run(8'h03, 0, 1'b0, 1'b0);
    run(8'hAA, 0, 1'b0, 1'b0);
    run(8'hFE, 0, 1'b0, 1'b0);
    run(8'h03, 0, 1'b0, 1'b0);
    run(8'h00, 0, 1'b0, 1'b0);
    run(8'hFF, 10, 1'b1, 1'b0);
    run(8'h00, 0, 1'b0, 1'b0);
    run(8'hFF, 12, 1'b0, 1'b0);
    run(8'h00, 0, 1'b0, 1'b0);

    // Reset in the middle of a ramp to all-ones.
    @(negedge clk);
    bus.tgt_valid = 1'b1;
    bus.tgt_code  = 8'hFF;
    bus.abort     = 1'b0;
    @(posedge clk); #1;
    e0 = cyc;
    bus.tgt_valid = 1'b0;
    chgq.push_back('{cyc: e0 + SD, lvl: 1});
    ramp_s = e0;
    ramp_e = e0 + W * SD;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_code", int'(bus.codeOut), 0);
    chk("midrst_level", int'(bus.level), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_ready", int'(bus.tgt_ready), 1);
    evq.delete();
    chgq.delete();
    ramp_e = 0;
    m_lvl  = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        code = 8'($urandom);
        while (therm_level(code) >= 0) code = 8'($urandom);
      end else if (sel == 2) begin
        code = therm(m_lvl);
      end else begin
        lvl  = $urandom_range(0, W);
        code = therm(lvl);
      end
      run(code,
          ($urandom_range(0, 2) == 0) ? $urandom_range(1, W * SD + 2) : 0,
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    bus.abort     = 1'b0;
    bus.tgt_valid = 1'b0;
    repeat (W * SD + 4) @(negedge clk);
    chk("events_drained", evq.size(), 0);
    chk("steps_drained", chgq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
